// File: rtl/guitar_pkg.sv
// Shared guitar note definitions: note codes, open-string note frequencies and nominal periods.
package guitar_pkg;

    typedef enum logic [2:0] {
        NOTE_A = 3'd0,
        NOTE_B = 3'd1,
        NOTE_C = 3'd2,
        NOTE_D = 3'd3,
        NOTE_E = 3'd4,
        NOTE_F = 3'd5,
        NOTE_G = 3'd6
    } note_t;

    localparam int CLK_MHZ_DEF = 25;
    localparam int NUM_NOTES   = 7;

    localparam int HZ_A = 220;
    localparam int HZ_B = 247;
    localparam int HZ_C = 261;
    localparam int HZ_D = 294;
    localparam int HZ_E = 330;
    localparam int HZ_F = 349;
    localparam int HZ_G = 392;

    function automatic int note_hz(input int n);
        case (n)
            0:       return HZ_A;
            1:       return HZ_B;
            2:       return HZ_C;
            3:       return HZ_D;
            4:       return HZ_E;
            5:       return HZ_F;
            default: return HZ_G;
        endcase
    endfunction

    // Full period of a square wave whose half period is rounded down then padded by one cycle.
    function automatic int nominal_period(input int clk_mhz, input int n);
        int h;
        h = (clk_mhz * 1000000) / note_hz(n) / 2;
        return 2 * (h + 1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes wave_in, optionally deglitches it (PITCH_DECODER_GLITCH_FILTER_EN), flags rising edges.
// Latency: 2 cycles to the rise pulse (+4 with the filter); backpressure: none, free-running.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic s1;
    logic s2;
    logic lvl;
    logic lvl_d;

`ifdef PITCH_DECODER_GLITCH_FILTER_EN
    logic [1:0] stable_cnt;

    // lvl follows s2 only after s2 has disagreed with it for 4 consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl        <= 1'b0;
            stable_cnt <= 2'd0;
        end else if (s2 == lvl) begin
            stable_cnt <= 2'd0;
        end else if (stable_cnt == 2'd3) begin
            lvl        <= s2;
            stable_cnt <= 2'd0;
        end else begin
            stable_cnt <= stable_cnt + 2'd1;
        end
    end
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/pitch_decoder.sv
// Measures rising-to-rising periods of wave_in and locks onto notes A..G (filter: PITCH_DECODER_GLITCH_FILTER_EN).
// Latency: edge to period capture 3 cycles (+4 with filter); capture to note_valid/note_strobe 1 cycle.
// Backpressure: none; free-running, outputs are levels plus a one-cycle strobe.
module pitch_decoder
    import guitar_pkg::*;
#(
    parameter int CLK_MHZ     = CLK_MHZ_DEF,
    parameter int TOL         = 512,
    parameter int MATCH_COUNT = 3,
    parameter int TIMEOUT     = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wave_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_strobe,
    output logic [19:0] period
);
    typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOCKED} state_t;

    localparam logic [19:0] CNT_MAX = '1;
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
    localparam logic [2:0]  MC      = 3'(MATCH_COUNT);

    logic        rise;
    logic [19:0] cnt;
    logic        cap;
    state_t      state;
    note_t       last_note;
    logic [2:0]  mcnt;
    logic [2:0]  mcnt_nxt;
    logic        hit;
    note_t       hit_note;
    int          diff;

    edge_sync u_sync (
        .clk  (clk),
        .rst  (reset),
        .din  (wave_in),
        .rise (rise)
    );

    // Descending scan so the lowest matching code is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_note = NOTE_A;
        diff     = 0;
        for (int n = NUM_NOTES - 1; n >= 0; n--) begin
            diff = int'(period) - nominal_period(CLK_MHZ, n);
            if (diff <= TOL && diff >= -TOL) begin
                hit      = 1'b1;
                hit_note = note_t'(3'(n));
            end
        end
    end

    always_comb begin
        mcnt_nxt = 3'd0;
        if (hit) begin
            mcnt_nxt = (mcnt != 3'd0 && hit_note == last_note) ? mcnt + 3'd1 : 3'd1;
        end
    end

    // The captured period is registered first and classified one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 20'd0;
            cap         <= 1'b0;
            period      <= 20'd0;
            mcnt        <= 3'd0;
            last_note   <= NOTE_A;
            note        <= 3'd0;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            cap         <= 1'b0;
            cnt         <= (cnt == CNT_MAX) ? cnt : cnt + 20'd1;

            if (rise) begin
                cnt <= 20'd0;
                if (state == ST_IDLE) begin
                    state <= ST_MEASURE;
                end else begin
                    period <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 20'd1;
                    cap    <= 1'b1;
                end
            end else if (cnt == TO_LAST) begin
                state      <= ST_IDLE;
                note_valid <= 1'b0;
                mcnt       <= 3'd0;
            end

            if (cap && !(state == ST_LOCKED && hit && hit_note == note)) begin
                mcnt      <= mcnt_nxt;
                last_note <= hit_note;
                if (mcnt_nxt >= MC) begin
                    state       <= ST_LOCKED;
                    note        <= hit_note;
                    note_valid  <= 1'b1;
                    note_strobe <= 1'b1;
                end else begin
                    state      <= ST_MEASURE;
                    note_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pitch_decoder.sv
// Directed bench for pitch_decoder at a 1 MHz clock so each note period is a few thousand cycles.
module tb_pitch_decoder;
    import guitar_pkg::*;

    localparam int CLK_MHZ = 1;
    localparam int TOL     = 64;
    localparam int MC      = 3;
    localparam int TIMEOUT = 5000;

    // Nominal periods at 1 MHz: A 4546, E 3032, G 2552.
    localparam int PA        = 4546;
    localparam int PE        = 3032;
    localparam int PG        = 2552;
    localparam int PE_HI     = PE + TOL;
    localparam int PE_OUT    = PE + TOL + 1;
    localparam int GLITCH_AT = 3273;

`ifdef PITCH_DECODER_GLITCH_FILTER_EN
    localparam int LAT   = 7;
    localparam int G_VLD = 1;
    localparam int G_PER = PA;
`else
    localparam int LAT   = 3;
    localparam int G_VLD = 0;
    localparam int G_PER = GLITCH_AT;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        wave_in = 1'b0;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_strobe;
    logic [19:0] period;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rise_cyc = 0;
    int lat_cap = 0;
    int lat_valid = 0;
    int lat_drop = 0;
    int strobe_cnt = 0;
    int base = 0;
    logic [19:0] per_d = 20'd0;
    logic        vld_d = 1'b0;

    pitch_decoder #(
        .CLK_MHZ     (CLK_MHZ),
        .TOL         (TOL),
        .MATCH_COUNT (MC),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wave_in     (wave_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_strobe (note_strobe),
        .period      (period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Latencies are measured from the cycle the bench drove the last main rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (note_strobe) strobe_cnt++;
        if (period != per_d) lat_cap = cyc - rise_cyc;
        if (note_valid && !vld_d) lat_valid = cyc - rise_cyc;
        if (!note_valid && vld_d) lat_drop = cyc - rise_cyc;
        per_d = period;
        vld_d = note_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_wave(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            wave_in  = 1'b1;
            rise_cyc = cyc;
            tick(p / 2);
            wave_in  = 1'b0;
            tick(p - p / 2);
        end
    endtask

    // One A period with a 2-cycle pulse in the low half.
    task automatic glitch_period();
        wave_in  = 1'b1;
        rise_cyc = cyc;
        tick(PA / 2);
        wave_in = 1'b0;
        tick(GLITCH_AT - PA / 2);
        wave_in = 1'b1;
        tick(2);
        wave_in = 1'b0;
        tick(PA - GLITCH_AT - 2);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        tick(3);
        chk("rst_note", int'(note), 0);
        chk("rst_valid", int'(note_valid), 0);
        chk("rst_strobe", int'(note_strobe), 0);
        chk("rst_period", int'(period), 0);
        reset = 1'b0;
        tick(2);

        chk("nom25_A", nominal_period(25, 0), 113638);
        chk("nom25_B", nominal_period(25, 1), 101216);
        chk("nom25_C", nominal_period(25, 2), 95786);
        chk("nom25_D", nominal_period(25, 3), 85036);
        chk("nom25_E", nominal_period(25, 4), 75758);
        chk("nom25_F", nominal_period(25, 5), 71634);
        chk("nom25_G", nominal_period(25, 6), 63776);

        base = strobe_cnt;
        run_wave(PA, 4);
        chk("a_lat_cap", lat_cap, LAT);
        chk("a_lat_valid", lat_valid, LAT + 1);
        chk("a_period", int'(period), PA);
        chk("a_note", int'(note), 0);
        chk("a_valid", int'(note_valid), 1);
        chk("a_strobes", strobe_cnt - base, 1);

        glitch_period();
        chk("glitch_valid", int'(note_valid), G_VLD);
        chk("glitch_period", int'(period), G_PER);
        chk("glitch_note", int'(note), 0);

        tick(TIMEOUT);
        chk("idle_valid", int'(note_valid), 0);
        run_wave(PE_HI, 1);
        chk("idle_edge_no_cap", int'(period), G_PER);
        chk("idle_edge_valid", int'(note_valid), 0);

        base = strobe_cnt;
        run_wave(PE_HI, 3);
        chk("e_tol_note", int'(note), 4);
        chk("e_tol_valid", int'(note_valid), 1);
        chk("e_tol_period", int'(period), PE_HI);
        chk("e_tol_strobes", strobe_cnt - base, 1);

        base = strobe_cnt;
        run_wave(PG, 4);
        chk("g_lat_drop", lat_drop, LAT + 1);
        chk("g_note", int'(note), 6);
        chk("g_valid", int'(note_valid), 1);
        chk("g_strobes", strobe_cnt - base, 1);

        reset = 1'b1;
        #1;
        chk("arst_note", int'(note), 0);
        chk("arst_valid", int'(note_valid), 0);
        chk("arst_strobe", int'(note_strobe), 0);
        chk("arst_period", int'(period), 0);
        tick(2);
        reset = 1'b0;
        run_wave(PG, 3);
        chk("relock_3_edges", int'(note_valid), 0);
        run_wave(PG, 1);
        chk("relock_4_edges", int'(note_valid), 1);
        chk("relock_note", int'(note), 6);

        tick(TIMEOUT);
        chk("to_valid", int'(note_valid), 0);
        chk("to_lat_drop", lat_drop, TIMEOUT + LAT);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        base = strobe_cnt;
        run_wave(PE_OUT, 4);
        chk("e_out_valid", int'(note_valid), 0);
        chk("e_out_strobes", strobe_cnt - base, 0);
        chk("e_out_period", int'(period), PE_OUT);

        // Next rise lands exactly on the timeout cycle; the capture must still happen.
        run_wave(TIMEOUT, 1);
        wave_in  = 1'b1;
        rise_cyc = cyc;
        tick(LAT + 3);
        chk("to_edge_period", int'(period), TIMEOUT);
        chk("to_edge_lat", lat_cap, LAT);
        wave_in = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
